// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the I2S transmitter and receiver.
//   DEFAULT_CLK_DIV      audio_clk cycles per BCLK period
//   DEFAULT_SAMPLE_WIDTH bits per channel sample
//   DEFAULT_SLOT_WIDTH   BCLKs per channel slot
//   stereo_sample_t      one left/right pair of signed 16-bit samples
package i2s_pkg;

    localparam int DEFAULT_CLK_DIV      = 64;
    localparam int DEFAULT_SAMPLE_WIDTH = 16;
    localparam int DEFAULT_SLOT_WIDTH   = 32;

    typedef struct packed {
        logic signed [15:0] left;
        logic signed [15:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: BCLK/LRCLK divider for the I2S transmitter.
// div_cnt counts audio_clk cycles inside one BCLK period. bit_cnt counts BCLKs
// inside one stereo frame (left slot, then right slot).
// Ports:
//   audio_clk    system clock, all logic on posedge
//   rst_in       synchronous active-high reset
//   bclk         registered bit clock, low for the first half of each period
//   lrclk        registered word select, 0 = left slot, 1 = right slot
//   fall_strobe  high in the cycle just before a BCLK falling edge
//   bit_pos      frame bit index that becomes current at the next falling edge
//   frame_load   high in the last cycle of a frame (fall_strobe on the last bit)
module i2s_clk_gen #(
    parameter int CLK_DIV    = 64,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                            audio_clk,
    input  logic                            rst_in,
    output logic                            bclk,
    output logic                            lrclk,
    output logic                            fall_strobe,
    output logic [$clog2(2*SLOT_WIDTH)-1:0] bit_pos,
    output logic                            frame_load
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_SIZE = BIT_W'(SLOT_WIDTH);

    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic             bclk_reg, lrclk_reg;

    always_comb begin
        fall_strobe  = (div_cnt_reg == DIV_LAST);
        frame_load   = fall_strobe && (bit_cnt_reg == BIT_LAST);
        div_cnt_next = fall_strobe ? '0 : div_cnt_reg + 1'b1;
        bit_cnt_next = bit_cnt_reg;
        if (fall_strobe) begin
            bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
        end
    end

    // bclk/lrclk are registered from the next counter values so they always
    // agree with the counters in the same cycle.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            bclk_reg    <= 1'b0;
            lrclk_reg   <= 1'b0;
        end else begin
            div_cnt_reg <= div_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            bclk_reg    <= (div_cnt_next >= DIV_HALF);
            lrclk_reg   <= (bit_cnt_next >= SLOT_SIZE);
        end
    end

    assign bclk    = bclk_reg;
    assign lrclk   = lrclk_reg;
    assign bit_pos = bit_cnt_next;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter for stereo samples going to an external DAC.
// Upstream samples go through a single-entry valid/ready holding buffer. At the
// end of every frame the buffer moves into the frame latch, or zeros are loaded
// if it is empty (underrun). The latched pair is then serialised MSB first.
// Build option: define I2S_TX_LEFT_JUSTIFIED_EN for left-justified data (MSB on
// the LRCLK edge); by default the standard I2S one-bit delay is used.
// Ports:
//   audio_clk, rst_in          clock and synchronous active-high reset
//   left_in, right_in          signed samples, taken when valid && ready
//   sample_valid_in            upstream sample valid
//   sample_ready_out           holding buffer empty
//   bclk_out, lrclk_out        bit clock and word select (0 = left)
//   sdata_out                  serial data, changes on BCLK falling edges
//   frame_start_out            one-cycle pulse when a frame is loaded
//   underrun_out               one-cycle pulse when that load found no sample
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV      = DEFAULT_CLK_DIV,
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = DEFAULT_SLOT_WIDTH
) (
    input  logic                           audio_clk,
    input  logic                           rst_in,
    input  logic signed [SAMPLE_WIDTH-1:0] left_in,
    input  logic signed [SAMPLE_WIDTH-1:0] right_in,
    input  logic                           sample_valid_in,
    output logic                           sample_ready_out,
    output logic                           bclk_out,
    output logic                           lrclk_out,
    output logic                           sdata_out,
    output logic                           frame_start_out,
    output logic                           underrun_out
);

    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam logic [BIT_W-1:0] SLOT_SIZE = BIT_W'(SLOT_WIDTH);

    logic             fall_strobe;
    logic             frame_load;
    logic [BIT_W-1:0] bit_pos;

    i2s_clk_gen #(
        .CLK_DIV    (CLK_DIV),
        .SLOT_WIDTH (SLOT_WIDTH)
    ) u_clk_gen (
        .audio_clk   (audio_clk),
        .rst_in      (rst_in),
        .bclk        (bclk_out),
        .lrclk       (lrclk_out),
        .fall_strobe (fall_strobe),
        .bit_pos     (bit_pos),
        .frame_load  (frame_load)
    );

    logic [SAMPLE_WIDTH-1:0] hold_left_reg,  hold_left_next;
    logic [SAMPLE_WIDTH-1:0] hold_right_reg, hold_right_next;
    logic                    hold_full_reg,  hold_full_next;
    logic [SAMPLE_WIDTH-1:0] frame_left_reg,  frame_left_next;
    logic [SAMPLE_WIDTH-1:0] frame_right_reg, frame_right_next;
    logic                    sdata_reg, frame_start_reg, underrun_reg;
    logic                    transfer;

    // A transfer coinciding with a load while empty lands in the buffer after
    // the load has already taken zeros, so it waits for the following frame.
    always_comb begin
        transfer         = sample_valid_in && !hold_full_reg;
        hold_left_next   = hold_left_reg;
        hold_right_next  = hold_right_reg;
        hold_full_next   = hold_full_reg;
        frame_left_next  = frame_left_reg;
        frame_right_next = frame_right_reg;
        if (frame_load) begin
            frame_left_next  = hold_full_reg ? hold_left_reg  : '0;
            frame_right_next = hold_full_reg ? hold_right_reg : '0;
            hold_full_next   = 1'b0;
        end
        if (transfer) begin
            hold_left_next  = left_in;
            hold_right_next = right_in;
            hold_full_next  = 1'b1;
        end
    end

    // Bit mux for the bit that becomes current at the next falling edge. It
    // reads the next latch value so the first bit of a fresh frame (needed at
    // p = 0 in left-justified mode) already comes from the new sample.
    logic                    slot_right;
    logic [BIT_W-1:0]        slot_pos;
    logic [SAMPLE_WIDTH-1:0] slot_word;
    logic [SAMPLE_WIDTH-1:0] bit_hit;
    logic                    sdata_bit;

    assign slot_right = (bit_pos >= SLOT_SIZE);
    assign slot_pos   = slot_right ? bit_pos - SLOT_SIZE : bit_pos;
    assign slot_word  = slot_right ? frame_right_next : frame_left_next;

    // Each sample bit gi owns exactly one slot position; every other position
    // (the delay bit and the padding) matches nothing and reads as 0.
    for (genvar gi = 0; gi < SAMPLE_WIDTH; gi++) begin : g_bit_map
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
        assign bit_hit[gi] = (slot_pos == BIT_W'(SAMPLE_WIDTH - 1 - gi)) && slot_word[gi];
`else
        assign bit_hit[gi] = (slot_pos == BIT_W'(SAMPLE_WIDTH - gi)) && slot_word[gi];
`endif
    end

    assign sdata_bit = |bit_hit;

    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            hold_left_reg   <= '0;
            hold_right_reg  <= '0;
            hold_full_reg   <= 1'b0;
            frame_left_reg  <= '0;
            frame_right_reg <= '0;
            sdata_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            underrun_reg    <= 1'b0;
        end else begin
            hold_left_reg   <= hold_left_next;
            hold_right_reg  <= hold_right_next;
            hold_full_reg   <= hold_full_next;
            frame_left_reg  <= frame_left_next;
            frame_right_reg <= frame_right_next;
            if (fall_strobe) begin
                sdata_reg <= sdata_bit;
            end
            frame_start_reg <= frame_load;
            underrun_reg    <= frame_load && !hold_full_reg;
        end
    end

    assign sample_ready_out = !hold_full_reg;
    assign sdata_out        = sdata_reg;
    assign frame_start_out  = frame_start_reg;
    assign underrun_out     = underrun_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx with default parameters.
// A reference model tracks the frame position and a queue of accepted samples.
// Samples are pushed to the queue as they are handed to the DUT and popped at
// each frame load. Every cycle the expected bclk/lrclk/frame_start/underrun/
// ready are compared, and at each frame end the bits recovered from sdata (on
// BCLK high) are compared with the frame built from the expected sample.
`timescale 1ns/1ps
module tb_i2s_tx;
    import i2s_pkg::*;

    localparam int FRAME = 4096;
    localparam int DIV   = 64;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    localparam logic [1:0] MSB_P0_EXP = 2'b01;
`else
    localparam logic [1:0] MSB_P0_EXP = 2'b00;
`endif

    logic        audio_clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] left_in = '0;
    logic [15:0] right_in = '0;
    logic        sample_valid_in = 1'b0;
    logic        sample_ready_out, bclk_out, lrclk_out, sdata_out;
    logic        frame_start_out, underrun_out;

    i2s_tx dut (
        .audio_clk        (audio_clk),
        .rst_in           (rst_in),
        .left_in          (left_in),
        .right_in         (right_in),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
        .bclk_out         (bclk_out),
        .lrclk_out        (lrclk_out),
        .sdata_out        (sdata_out),
        .frame_start_out  (frame_start_out),
        .underrun_out     (underrun_out)
    );

    always #5 audio_clk = ~audio_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Expected 64 serial bits of one frame, index = bit_cnt.
    function automatic logic [63:0] frame_bits(input stereo_sample_t s);
        logic [63:0] v;
        logic [15:0] w;
        v = '0;
        for (int k = 0; k < 64; k++) begin
            int p;
            p = k % 32;
            w = (k < 32) ? s.left : s.right;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
            if (p < 16) v[k] = w[15 - p];
`else
            if (p >= 1 && p <= 16) v[k] = w[16 - p];
`endif
        end
        return v;
    endfunction

    // Reference model state, advanced on each rising edge.
    int             tcnt = 0;
    stereo_sample_t sample_q[$];
    stereo_sample_t exp_frame = '0;
    bit             exp_fs = 1'b0;
    bit             exp_ur = 1'b0;
    bit             checking = 1'b0;
    bit             xfer;
    logic [63:0]    cap = '0;
    int             frame_no = 0;
    int             dc, bc;

    initial forever begin
        @(posedge audio_clk);
        if (rst_in) begin
            tcnt = 0;
            sample_q.delete();
            exp_frame = '0;
            exp_fs = 1'b0;
            exp_ur = 1'b0;
        end else begin
            xfer = sample_valid_in && (sample_q.size() == 0);
            exp_fs = 1'b0;
            exp_ur = 1'b0;
            if (tcnt == FRAME - 1) begin
                exp_fs = 1'b1;
                if (sample_q.size() > 0) begin
                    exp_frame = sample_q.pop_front();
                end else begin
                    exp_frame = '0;
                    exp_ur = 1'b1;
                end
            end
            if (xfer) sample_q.push_back({left_in, right_in});
            tcnt = (tcnt + 1) % FRAME;
        end
    end

    initial forever begin
        @(negedge audio_clk);
        if (checking) begin
            dc = tcnt % DIV;
            bc = tcnt / DIV;
            check_eq("status", {59'd0, bclk_out, lrclk_out, frame_start_out, underrun_out, sample_ready_out},
                     {59'd0, dc >= DIV/2, bc >= 32, exp_fs, exp_ur, sample_q.size() == 0});
            if (dc == DIV/2) cap[bc] = sdata_out;
            if (tcnt == FRAME - 1) begin
                check_eq($sformatf("frame%0d", frame_no), cap, frame_bits(exp_frame));
                $display("[TB] frame %0d L=%h R=%h sdata_bits=%h", frame_no, exp_frame.left, exp_frame.right, cap);
                frame_no++;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge with
    // valid still asserted.
    task automatic push(input logic [15:0] l, input logic [15:0] r);
        bit ok;
        ok = 1'b0;
        sample_valid_in = 1'b1;
        left_in = l;
        right_in = r;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (sample_ready_out) begin
                ok = 1'b1;
                break;
            end
            @(negedge audio_clk);
        end
        check_eq("push_accept", {63'd0, ok}, 64'd1);
        @(negedge audio_clk);
        $display("[TB] push L=%h R=%h accepted, model phase %0d", l, r, tcnt);
    endtask

    task automatic wait_fs(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge audio_clk);
            if (frame_start_out) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, {63'd0, seen}, 64'd1);
    endtask

    int gap;

    initial begin
        rst_in = 1'b1;
        repeat (3) @(negedge audio_clk);
        checking = 1'b1;
        check_eq("reset_state", {58'd0, bclk_out, lrclk_out, sdata_out, frame_start_out, underrun_out, sample_ready_out}, 64'd1);
        rst_in = 1'b0;

        // Idle: zeros and underrun every frame.
        wait_fs("idle_fs1");
        wait_fs("idle_fs2");

        // Known pattern.
        push(16'hA5C3, 16'h8001);
        sample_valid_in = 1'b0;
        wait_fs("known_load");
        wait_fs("known_done");

        // One sample per frame, right after each frame start.
        for (int i = 0; i < 6; i++) begin
            push(16'($urandom), 16'($urandom));
            sample_valid_in = 1'b0;
            wait_fs("stream_fs");
        end

        // Back-to-back with valid held high.
        push(16'h1234, 16'hFEDC);
        push(16'h7FFF, 16'h8000);
        sample_valid_in = 1'b0;
        check_eq("b2b_accept_phase", 64'(tcnt), 64'd1);
        wait_fs("b2b_fs1");
        wait_fs("b2b_fs2");

        // One-cycle reset in the middle of the right slot.
        repeat (45 * DIV) @(negedge audio_clk);
        rst_in = 1'b1;
        @(negedge audio_clk);
        check_eq("reset_mid", {58'd0, bclk_out, lrclk_out, sdata_out, frame_start_out, underrun_out, sample_ready_out}, 64'd1);
        rst_in = 1'b0;
        gap = 0;
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge audio_clk);
            gap++;
            if (frame_start_out) break;
        end
        check_eq("reset_fs_gap", 64'(gap), 64'(FRAME));

        // MSB-only sample: position of the MSB relative to the LRCLK edge.
        push(16'h8000, 16'h0000);
        sample_valid_in = 1'b0;
        wait_fs("msb_load");
        check_eq("msb_p0", {62'd0, lrclk_out, sdata_out}, {62'd0, MSB_P0_EXP});
        wait_fs("msb_done");

        repeat (4) @(negedge audio_clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
